mux_2to1_rr: RTL and testbench

Two-input stream merger: round-robin arbitrates between two valid/ready input channels of `width` bits and forwards one word per cycle through a single registered output stage. Each output word carries a source tag, `o_sel`, so a downstream 1-to-2 demux can route replies or data back to the originating channel. It sits between two producers and one shared consumer in the combinational-logic datapath, and is the merging counterpart of the 1-to-2 demux.

---
 rtl/mux_pkg.sv | 16 +
 rtl/mux_2to1_rr_arbiter.sv | 30 +++
 rtl/mux_2to1_rr.sv | 73 +++++++
 tb/tb_mux_2to1_rr.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the 2:1 stream merger and its 1:2 demux counterpart.
package mux_pkg;

    localparam int WIDTH_DEFAULT = 2;

    // Channel ids; the demux side uses the same encoding for its sel input.
    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    // Occupancy of the one-entry output register.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/mux_2to1_rr_arbiter.sv
// Two-requester round-robin arbiter; remembers the last granted channel.
module rr_arbiter_2
    import mux_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic r_last;

    // Grant a lone requester; under contention grant the channel not served last.
    always_comb begin
        grant    = '0;
        grant[0] = req[0] && (!req[1] || (r_last == CH1));
        grant[1] = req[1] && (!req[0] || (r_last == CH0));
    end

    // Record the granted channel only when a transfer actually happens.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= CH1;
        end else if (advance) begin
            r_last <= grant[1] ? CH1 : CH0;
        end
    end

endmodule

// File: rtl/mux_2to1_rr.sv
// Round-robin 2:1 valid/ready stream merger with a registered, tagged output.
module mux_2to1_rr
    import mux_pkg::*;
#(
    parameter int width = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] i0,
    input  logic             i0_valid,
    output logic             i0_ready,
    input  logic [width-1:0] i1,
    input  logic             i1_valid,
    output logic             i1_ready,
    output logic [width-1:0] o,
    output logic             o_sel,
    output logic             o_valid,
    input  logic             o_ready
);

    out_state_e       r_state;
    logic [width-1:0] r_data;
    logic             r_sel;

    logic [1:0]       w_grant;
    logic             w_space;
    logic             w_xfer0;
    logic             w_xfer1;
    logic             w_advance;

    // Output stage can accept a word when empty or being popped this cycle;
    // readys are held low while reset is asserted.
    always_comb begin
        w_space   = (r_state == ST_EMPTY) || o_ready;
        i0_ready  = w_grant[0] && w_space && !rst;
        i1_ready  = w_grant[1] && w_space && !rst;
        w_xfer0   = i0_valid && i0_ready;
        w_xfer1   = i1_valid && i1_ready;
        w_advance = w_xfer0 || w_xfer1;
    end

    rr_arbiter_2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({i1_valid, i0_valid}),
        .advance (w_advance),
        .grant   (w_grant)
    );

    // Load on transfer (pop and load may coincide), drain on pop, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_data  <= '0;
            r_sel   <= CH0;
        end else if (w_xfer1) begin
            r_state <= ST_FULL;
            r_data  <= i1;
            r_sel   <= CH1;
        end else if (w_xfer0) begin
            r_state <= ST_FULL;
            r_data  <= i0;
            r_sel   <= CH0;
        end else if ((r_state == ST_FULL) && o_ready) begin
            r_state <= ST_EMPTY;
        end
    end

    assign o       = r_data;
    assign o_sel   = r_sel;
    assign o_valid = (r_state == ST_FULL);

endmodule

// File: tb/tb_mux_2to1_rr.sv
// Directed self-checking bench for mux_2to1_rr (width 2).
module tb_mux_2to1_rr;

    logic       clk;
    logic       rst;
    logic [1:0] i0;
    logic       i0_valid;
    logic       i0_ready;
    logic [1:0] i1;
    logic       i1_valid;
    logic       i1_ready;
    logic [1:0] o;
    logic       o_sel;
    logic       o_valid;
    logic       o_ready;

    int n_cmp = 0;
    int n_bad = 0;

    mux_2to1_rr #(.width(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .i0       (i0),
        .i0_valid (i0_valid),
        .i0_ready (i0_ready),
        .i1       (i1),
        .i1_valid (i1_valid),
        .i1_ready (i1_ready),
        .o        (o),
        .o_sel    (o_sel),
        .o_valid  (o_valid),
        .o_ready  (o_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; i0 = 2'b11; i0_valid = 1'b1; i1 = 2'b00; i1_valid = 1'b0; o_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL rst_o_valid got=%b exp=0", o_valid); end
            n_cmp++; if (o !== 2'b00) begin n_bad++; $display("FAIL rst_o got=%b exp=00", o); end
            n_cmp++; if (i0_ready !== 1'b0) begin n_bad++; $display("FAIL rst_i0_ready got=%b exp=0", i0_ready); end
        end
        rst = 1'b0;
        #1;
        n_cmp++; if (i0_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_i0_ready got=%b exp=1", i0_ready); end
        tick();
        n_cmp++; if (o !== 2'b11 || o_sel !== 1'b0 || o_valid !== 1'b1) begin
            n_bad++; $display("FAIL post_rst_out got o=%b sel=%b v=%b exp o=11 sel=0 v=1", o, o_sel, o_valid);
        end
        i0_valid = 1'b0;
        tick();
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL post_rst_drain got=%b exp=0", o_valid); end
    endtask

    task automatic test_single_stream;
        logic [1:0] v;
        i1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            v = 2'(k);
            i1 = v;
            #1;
            n_cmp++; if (i1_ready !== 1'b1) begin n_bad++; $display("FAIL stream_ready[%0d] got=%b exp=1", k, i1_ready); end
            tick();
            n_cmp++; if (o !== v || o_sel !== 1'b1 || o_valid !== 1'b1) begin
                n_bad++; $display("FAIL stream_out[%0d] got o=%b sel=%b v=%b exp o=%b sel=1 v=1", k, o, o_sel, o_valid, v);
            end
        end
        i1_valid = 1'b0;
        tick();
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL stream_drain got=%b exp=0", o_valid); end
    endtask

    task automatic test_contention;
        logic       es;
        logic [1:0] eo;
        i0 = 2'b01; i1 = 2'b10; i0_valid = 1'b1; i1_valid = 1'b1; o_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            es = (k % 2 == 1);
            eo = es ? 2'b10 : 2'b01;
            #1;
            n_cmp++; if (i0_ready !== !es || i1_ready !== es) begin
                n_bad++; $display("FAIL cont_ready[%0d] got r0=%b r1=%b exp r0=%b r1=%b", k, i0_ready, i1_ready, !es, es);
            end
            tick();
            n_cmp++; if (o_sel !== es || o !== eo || o_valid !== 1'b1) begin
                n_bad++; $display("FAIL cont_out[%0d] got o=%b sel=%b v=%b exp o=%b sel=%b v=1", k, o, o_sel, o_valid, eo, es);
            end
        end
    endtask

    task automatic test_backpressure;
        o_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (i0_ready !== 1'b0 || i1_ready !== 1'b0) begin
                n_bad++; $display("FAIL bp_ready[%0d] got r0=%b r1=%b exp 0 0", k, i0_ready, i1_ready);
            end
            tick();
            n_cmp++; if (o !== 2'b10 || o_sel !== 1'b1 || o_valid !== 1'b1) begin
                n_bad++; $display("FAIL bp_hold[%0d] got o=%b sel=%b v=%b exp o=10 sel=1 v=1", k, o, o_sel, o_valid);
            end
        end
        o_ready = 1'b1;
        #1;
        n_cmp++; if (i0_ready !== 1'b1 || i1_ready !== 1'b0) begin
            n_bad++; $display("FAIL bp_release_ready got r0=%b r1=%b exp 1 0", i0_ready, i1_ready);
        end
        tick();
        n_cmp++; if (o !== 2'b01 || o_sel !== 1'b0 || o_valid !== 1'b1) begin
            n_bad++; $display("FAIL bp_release_out got o=%b sel=%b v=%b exp o=01 sel=0 v=1", o, o_sel, o_valid);
        end
    endtask

    task automatic test_reset_midstream;
        // Last grant was channel 0; without reset the next would be channel 1.
        rst = 1'b1;
        #1;
        n_cmp++; if (i0_ready !== 1'b0 || i1_ready !== 1'b0) begin
            n_bad++; $display("FAIL mid_rst_ready got r0=%b r1=%b exp 0 0", i0_ready, i1_ready);
        end
        tick();
        n_cmp++; if (o_valid !== 1'b0 || o !== 2'b00 || o_sel !== 1'b0) begin
            n_bad++; $display("FAIL mid_rst_out got o=%b sel=%b v=%b exp o=00 sel=0 v=0", o, o_sel, o_valid);
        end
        rst = 1'b0;
        #1;
        n_cmp++; if (i0_ready !== 1'b1 || i1_ready !== 1'b0) begin
            n_bad++; $display("FAIL mid_rst_grant got r0=%b r1=%b exp 1 0", i0_ready, i1_ready);
        end
        tick();
        n_cmp++; if (o !== 2'b01 || o_sel !== 1'b0 || o_valid !== 1'b1) begin
            n_bad++; $display("FAIL mid_rst_first got o=%b sel=%b v=%b exp o=01 sel=0 v=1", o, o_sel, o_valid);
        end
    endtask

    task automatic test_idle;
        i0_valid = 1'b0; i1_valid = 1'b0; o_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (o_valid !== 1'b0 || o !== 2'b01 || o_sel !== 1'b0) begin
                n_bad++; $display("FAIL idle[%0d] got o=%b sel=%b v=%b exp o=01 sel=0 v=0", k, o, o_sel, o_valid);
            end
        end
        // last is still channel 0, so contention now goes to channel 1.
        i0_valid = 1'b1; i1_valid = 1'b1;
        #1;
        n_cmp++; if (i0_ready !== 1'b0 || i1_ready !== 1'b1) begin
            n_bad++; $display("FAIL idle_grant got r0=%b r1=%b exp 0 1", i0_ready, i1_ready);
        end
        tick();
        n_cmp++; if (o !== 2'b10 || o_sel !== 1'b1 || o_valid !== 1'b1) begin
            n_bad++; $display("FAIL idle_out got o=%b sel=%b v=%b exp o=10 sel=1 v=1", o, o_sel, o_valid);
        end
        i0_valid = 1'b0; i1_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; i0 = '0; i1 = '0; i0_valid = 1'b0; i1_valid = 1'b0; o_ready = 1'b1;
        test_reset();
        test_single_stream();
        test_contention();
        test_backpressure();
        test_reset_midstream();
        test_idle();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
